cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
Miss-handling state machine that sequences one cache during a miss. It fetches the whole 16-byte block from pipelined main memory, one word-read issued per cycle. It steers each returned word into the cache data array, then writes the tag. Its outputs drive the cache controller's miss_fixing, memory_address, memory_data_write and memory_tag_write inputs; memory data flows straight from memory to the controller and does not pass through this block.

Parameters:
ADDR_W, 16, address width in bits (byte addresses, 16-bit words at even addresses)
WORDS_PER_BLOCK, 8, words per cache block (block = 16 bytes)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
miss_detected  input  1  cache reports a miss on the current CPU access
miss_address  input  ADDR_W  byte address of the missing access
memory_data_valid  input  1  main memory returns one word this cycle (fixed pipelined latency)
mem_read  output  1  read request to main memory this cycle
mem_address  output  ADDR_W  byte address of the read request
fsm_busy  output  1  fill in progress; drives the controller's miss_fixing; also stalls the CPU
memory_address  output  ADDR_W  cache-side address for the word or tag being written
memory_data_write  output  1  write the returned word into the cache data array
memory_tag_write  output  1  write the tag and valid bit for the filled block

Behaviour:
- Reset (async, rst_n=0): state IDLE; issue and receive counters 0; base register 0; every output 0. Reset mid-fill aborts immediately; no tag write occurs, so the line stays invalid.
- base = miss_address with the low 4 bits cleared. It is captured on the IDLE->FILL transition and held until IDLE is re-entered.
- States: IDLE, FILL, TAG.
- IDLE:
  - All outputs 0.
  - miss_detected=1 at a clock edge -> FILL next cycle.
  - memory_data_valid is ignored.
- FILL:
  - fsm_busy=1.
  - While issue_cnt<8: mem_read=1 and mem_address=base+2*issue_cnt. issue_cnt increments every cycle; no backpressure.
  - When issue_cnt=8: mem_read=0.
  - memory_address=base+2*recv_cnt (combinational from the counter).
  - memory_data_write = memory_data_valid and recv_cnt<8. recv_cnt increments on each accepted word.
  - Transition to TAG on the edge where the 8th word is accepted.
  - Extra valids after the 8th word are ignored.
- TAG:
  - One cycle only: fsm_busy=1, memory_tag_write=1, memory_address=base, memory_data_write=0, mem_read=0.
  - Next state IDLE.
- Latency: with memory latency L, the first mem_read is 1 cycle after miss detection, and busy lasts 8+L+1 cycles (L counted so the word requested in cycle t is valid in cycle t+L).
- miss_detected while in FILL or TAG: ignored; no restart, base unchanged.
- Back-to-back misses: a miss seen in the IDLE cycle right after TAG starts a new fill.
- Address arithmetic is modulo 2^ADDR_W. The offset never exceeds 14, so no carry leaves the block; base 0xFFF0 covers 0xFFF0..0xFFFE.
- Counters are 4 bits wide and saturate at 8.
- All state and counters are registered. Outputs are Moore outputs except memory_data_write, which is gated combinationally by memory_data_valid.

Decomposition:
- Shared package holds:
  - BLOCK_OFFSET_BITS=4 and WORDS_PER_BLOCK=8;
  - state encoding constants IDLE=2'b00, FILL=2'b01, TAG=2'b10;
  - the word-stride constant 2.
- One sub-module, block_word_counter: a 4-bit saturating counter with async clear, enable and done flag, instantiated twice (issue and receive).

Test Plan:
- Reset then idle -> all outputs 0 for 20 cycles, including with random memory_data_valid pulses.
- miss at 0x1234, L=4 ->
  - mem_read high for 8 cycles with mem_address 0x1230, 0x1232, …, 0x123E;
  - eight memory_data_write pulses with memory_address 0x1230..0x123E in order;
  - then one memory_tag_write cycle with memory_address 0x1230;
  - fsm_busy high for exactly 13 cycles.
- miss at 0xFFFF -> addresses 0xFFF0..0xFFFE and no wrap to 0x0000; tag written at 0xFFF0.
- Second miss_detected at 0x4000 during a fill of 0x2000 -> ignored; all addresses stay 0x2000-based and a single tag write occurs.
- rst_n low after the 5th returned word -> all outputs 0 asynchronously, no tag write; a new miss after reset fills cleanly from word 0.
- Stalled memory (valid gaps of 3 cycles between words) -> data writes occur only on valid cycles and TAG follows the 8th valid; miss in the cycle after TAG starts a new fill.

Source files
------------

// File: rtl/cache_fill_fsm_pkg.sv
// cache_fill_fsm_pkg: block geometry, state encoding and word-offset helper for the miss-fill FSM
package cache_fill_fsm_pkg;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int WORD_STRIDE = 2;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    TAG  = 2'b10
  } state_t;
  function automatic logic [BLOCK_OFFSET_BITS-1:0] word_offset(input logic [CNT_W-1:0] idx);
    return BLOCK_OFFSET_BITS'(idx * WORD_STRIDE);
  endfunction
endpackage

// File: rtl/cache_fill_fsm_if.sv
// cache_fill_fsm_if: miss request, memory read port and cache-array write controls of the fill FSM
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic              fsm_busy;
  logic [ADDR_W-1:0] memory_address;
  logic              memory_data_write;
  logic              memory_tag_write;
  modport master (
    output miss_detected, miss_address, memory_data_valid,
    input  mem_read, mem_address, fsm_busy, memory_address, memory_data_write, memory_tag_write
  );
  modport slave (
    input  miss_detected, miss_address, memory_data_valid,
    output mem_read, mem_address, fsm_busy, memory_address, memory_data_write, memory_tag_write
  );
endinterface

// File: rtl/cache_fill_fsm_block_word_counter.sv
// block_word_counter: word counter that saturates at one block, cleared between fills
module block_word_counter import cache_fill_fsm_pkg::*; #(
  parameter int LIMIT = WORDS_PER_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  assign o_done = r_cnt == CNT_W'(LIMIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && !o_done) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: issues one word read per cycle for a missed block, steers returns into the data array, then writes the tag
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input logic             clk,
  input logic             rst_n,
  cache_fill_fsm_if.slave io_fill
);
  import cache_fill_fsm_pkg::*;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);
  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic              r_busy;
  logic              r_tag_wr;
  logic [CNT_W-1:0]  w_issue_cnt;
  logic [CNT_W-1:0]  w_recv_cnt;
  logic              w_issue_done;
  logic              w_recv_done;
  logic              w_idle;
  logic              w_fill;
  logic              w_mem_read;
  logic              w_data_wr;
  logic              w_last;
  assign w_idle = r_state == IDLE;
  assign w_fill = r_state == FILL;
  block_word_counter #(.LIMIT(WORDS_PER_BLOCK)) u_issue (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_idle),
    .i_en   (w_fill),
    .o_cnt  (w_issue_cnt),
    .o_done (w_issue_done)
  );
  block_word_counter #(.LIMIT(WORDS_PER_BLOCK)) u_recv (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_idle),
    .i_en   (w_data_wr),
    .o_cnt  (w_recv_cnt),
    .o_done (w_recv_done)
  );
  assign w_mem_read = w_fill && !w_issue_done;
  assign w_data_wr = w_fill && io_fill.memory_data_valid && !w_recv_done;
  assign w_last = w_data_wr && w_recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1);
  // base has its offset bits clear, so adding the word offset can never carry out of the block
  assign io_fill.mem_read = w_mem_read;
  assign io_fill.mem_address = w_mem_read ? r_base + ADDR_W'(word_offset(w_issue_cnt)) : '0;
  assign io_fill.memory_address = w_fill ? r_base + ADDR_W'(word_offset(w_recv_cnt)) : r_state == TAG ? r_base : '0;
  assign io_fill.memory_data_write = w_data_wr;
  assign io_fill.fsm_busy = r_busy;
  assign io_fill.memory_tag_write = r_tag_wr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_base <= '0;
      r_busy <= 1'b0;
      r_tag_wr <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (io_fill.miss_detected) begin
          r_state <= FILL;
          r_base <= io_fill.miss_address & ~OFFSET_MASK;
          r_busy <= 1'b1;
        end
        FILL: if (w_last) begin
          r_state <= TAG;
          r_tag_wr <= 1'b1;
        end
        TAG: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
          r_tag_wr <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy <= 1'b0;
          r_tag_wr <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: drives miss fills against a latency/gap memory model and checks the logged read, write and tag traffic
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  cache_fill_fsm_if #(.ADDR_W(16)) bus ();
  cache_fill_fsm #(.ADDR_W(16), .WORDS_PER_BLOCK(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .io_fill (bus)
  );
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int lat = 4, gap_len = 0, gap = 0, busy_n = 0, rd_first = -1, tag_cyc = -1, wr_last = -1;
  int req_q[$];
  logic [15:0] rd_q[$], wr_q[$], tag_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {bus.mem_read, bus.fsm_busy, bus.memory_data_write, bus.memory_tag_write,
              bus.mem_address, bus.memory_address}, 64'd0);
  endtask

  // one clock: drive this cycle's inputs just after the edge, sample outputs once settled
  task automatic tick(input logic miss, input logic [15:0] maddr, input logic extra_v);
    logic rdy, v;
    @(posedge clk);
    #1;
    cyc++;
    rdy = req_q.size() > 0 && req_q[0] + lat <= cyc;
    v = extra_v || (rdy && gap == 0);
    bus.miss_detected = miss;
    bus.miss_address = maddr;
    bus.memory_data_valid = v;
    #1;
    if (rdy && v) begin
      void'(req_q.pop_front());
      gap = gap_len;
    end else if (rdy && gap > 0) gap--;
    if (bus.mem_read) begin
      if (rd_q.size() == 0) rd_first = cyc;
      req_q.push_back(cyc);
      rd_q.push_back(bus.mem_address);
    end
    if (bus.memory_data_write) begin
      chk("write_on_valid", v, 1'b1);
      wr_q.push_back(bus.memory_address);
      wr_last = cyc;
    end
    if (bus.memory_tag_write) begin
      tag_q.push_back(bus.memory_address);
      tag_cyc = cyc;
    end
    if (bus.fsm_busy) busy_n++;
  endtask

  task automatic run_fill(input logic [15:0] a, input int L, input int G, input bit intrude, input int abort_at);
    logic [15:0] base;
    int c0, k;
    base = a & 16'hFFF0;
    lat = L; gap_len = G; gap = 0; busy_n = 0; rd_first = -1; tag_cyc = -1; wr_last = -1;
    rd_q.delete(); wr_q.delete(); tag_q.delete();
    tick(1'b1, a, 1'b0);
    chk("miss_cycle_not_busy", bus.fsm_busy, 1'b0);
    c0 = cyc;
    k = 0;
    while (tag_q.size() == 0 && k < 300) begin
      k++;
      tick(intrude && k >= 2 && k <= 6, 16'h4000, wr_q.size() == 8);
      if (abort_at > 0 && wr_q.size() == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle("abort_async_clear");
        req_q.delete();
        repeat (3) begin
          tick(1'b0, 16'h0000, 1'b0);
          chk_idle("abort_held_idle");
        end
        chk("abort_no_tag", tag_q.size(), 0);
        chk("abort_write_count", wr_q.size(), abort_at);
        rst_n = 1'b1;
        return;
      end
    end
    chk("tag_within_budget", tag_q.size(), 1);
    chk("read_count", rd_q.size(), 8);
    chk("write_count", wr_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("read_addr%0d", i), i < rd_q.size() ? rd_q[i] : 16'bx, 16'(base + 2 * i));
      chk($sformatf("write_addr%0d", i), i < wr_q.size() ? wr_q[i] : 16'bx, 16'(base + 2 * i));
    end
    chk("first_read_cycle", rd_first, c0 + 1);
    chk("tag_addr", tag_q.size() > 0 ? tag_q[0] : 16'bx, base);
    chk("tag_after_last_word", tag_cyc, wr_last + 1);
    chk("busy_span", busy_n, tag_cyc - c0);
    if (G == 0) chk("busy_len", busy_n, 9 + L);
  endtask

  initial begin
    bus.miss_detected = 1'b0;
    bus.miss_address = 16'h0000;
    bus.memory_data_valid = 1'b0;
    #1;
    chk_idle("reset_outputs");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 16'($urandom), 1'($urandom));
      chk_idle("idle_ignores_valid");
    end
    run_fill(16'h1234, 4, 0, 1'b0, 0);
    run_fill(16'hFFFF, 4, 0, 1'b0, 0);
    tick(1'b0, 16'h0000, 1'b0);
    chk_idle("idle_after_wrap_fill");
    run_fill(16'h2000, 3, 0, 1'b1, 0);
    repeat (12) tick(1'b0, 16'h0000, 1'b0);
    chk("intrude_single_tag", tag_q.size(), 1);
    chk_idle("intrude_back_to_idle");
    run_fill(16'($urandom), 4, 0, 1'b0, 5);
    tick(1'b0, 16'h0000, 1'b0);
    chk_idle("post_abort_idle");
    run_fill(16'($urandom), 4, 0, 1'b0, 0);
    run_fill(16'h5678, 2, 3, 1'b0, 0);
    run_fill(16'h9ABC, 1, 0, 1'b0, 0);
    repeat (6) begin
      repeat ($urandom_range(0, 3)) tick(1'b0, 16'($urandom), 1'b0);
      run_fill(16'($urandom), $urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
